// File: rtl/iigs_io_sequencer.sv
// rtl/iigs_io_sequencer.sv - sequences CPU $C0xx I/O accesses onto the adb, prtc and iwm strobed peripherals
//
// Purpose:
//   Decodes the low address byte of a $C0xx access to one of three peripherals.
//   It then issues a one-cen-period strobe carrying rw/addr/data and waits for the
//   target's ack. On a read it latches the returned byte. While the access is in
//   progress it holds the CPU with busy. Targets flagged in SLOW_MASK have their
//   strobe aligned to the 1 MHz slow_en tick.
//
// Optional feature:
//   IOSEQ_TIMEOUT_EN - when defined, an access that receives no ack within
//   TIMEOUT_CYCLES cen ticks in WAIT completes with err=1 and rd_data=8'hFF.
//
// Ports:
//   i_clk_sys     system clock
//   i_reset_n     async active-low reset
//   i_cen         fast clock enable; every state update qualifies on it
//   i_slow_en     one-clk_sys pulse at the 1 MHz rate
//   i_req         access request, sampled on a cen tick
//   i_req_wr      1 = write, 0 = read
//   i_req_addr    $C0xx low byte
//   i_req_din     write data
//   o_busy        access in progress (CPU must hold)
//   o_done        completion, one cen period
//   o_err         unmapped access or timeout, high with done
//   o_rd_data     read data, held until the next completion
//   o_tgt_strobe  one-hot strobe {iwm,prtc,adb}
//   o_tgt_rw      1 = read, 0 = write
//   o_tgt_addr    address to target
//   o_tgt_din     write data to target
//   i_tgt_dout    read data {iwm,prtc,adb}
//   i_tgt_ack     per-target ack level {iwm,prtc,adb}

module iigs_io_sequencer #(
  parameter logic [2:0]  SLOW_MASK      = 3'b100,
  parameter logic [7:0]  UNMAPPED_VAL   = 8'h00,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd64
) (
  input  logic        i_clk_sys,
  input  logic        i_reset_n,
  input  logic        i_cen,
  input  logic        i_slow_en,
  input  logic        i_req,
  input  logic        i_req_wr,
  input  logic [7:0]  i_req_addr,
  input  logic [7:0]  i_req_din,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_rd_data,
  output logic [2:0]  o_tgt_strobe,
  output logic        o_tgt_rw,
  output logic [7:0]  o_tgt_addr,
  output logic [7:0]  o_tgt_din,
  input  logic [23:0] i_tgt_dout,
  input  logic [2:0]  i_tgt_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_STROBE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic       r_tgt_rw;
  logic       r_slow_flag;
  logic [7:0] r_rd_data;
  logic [7:0] r_tgt_addr;
  logic [7:0] r_tgt_din;
  logic [2:0] r_tgt_strobe;
  logic [2:0] r_tgt_sel;

  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_err_nxt;
  logic       w_tgt_rw_nxt;
  logic [7:0] w_rd_data_nxt;
  logic [7:0] w_tgt_addr_nxt;
  logic [7:0] w_tgt_din_nxt;
  logic [2:0] w_tgt_strobe_nxt;
  logic [2:0] w_tgt_sel_nxt;
  logic       w_flag_clr;

  logic [2:0] w_dec_sel;
  logic [7:0] w_dec_addr;
  logic       w_dec_slow;
  logic       w_sel_ack;
  logic [7:0] w_sel_dout;

`ifdef IOSEQ_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic [15:0] w_to_cnt_nxt;
`endif

  // Address decode, one-hot {iwm,prtc,adb}; all-zero means unmapped.
  always_comb begin
    w_dec_sel = 3'b000;
    case (i_req_addr)
      8'h00, 8'h10, 8'h24, 8'h25, 8'h26, 8'h27, 8'h44, 8'h45,
      8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h70:
        w_dec_sel = 3'b001;
      8'h33, 8'h34:
        w_dec_sel = 3'b010;
      default:
        if (i_req_addr[7:4] == 4'hE) begin
          w_dec_sel = 3'b100;
        end
    endcase
  end

  // The clock chip sees a one-bit register select: $C033 (data) -> 0, $C034 (control) -> 1.
  assign w_dec_addr = w_dec_sel[1] ? {7'b0, ~i_req_addr[0]} : i_req_addr;
  assign w_dec_slow = |(w_dec_sel & SLOW_MASK);

  // Only the latched target's ack and data are looked at.
  assign w_sel_ack  = |(i_tgt_ack & r_tgt_sel);
  assign w_sel_dout = ({8{r_tgt_sel[0]}} & i_tgt_dout[7:0])
                    | ({8{r_tgt_sel[1]}} & i_tgt_dout[15:8])
                    | ({8{r_tgt_sel[2]}} & i_tgt_dout[23:16]);

  always_comb begin
    w_state_nxt      = r_state;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    w_rd_data_nxt    = r_rd_data;
    w_tgt_strobe_nxt = r_tgt_strobe;
    w_tgt_sel_nxt    = r_tgt_sel;
    w_tgt_rw_nxt     = r_tgt_rw;
    w_tgt_addr_nxt   = r_tgt_addr;
    w_tgt_din_nxt    = r_tgt_din;
    w_flag_clr       = 1'b0;
`ifdef IOSEQ_TIMEOUT_EN
    w_to_cnt_nxt     = r_to_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          if (w_dec_sel != 3'b000) begin
            w_tgt_sel_nxt  = w_dec_sel;
            w_tgt_rw_nxt   = ~i_req_wr;
            w_tgt_addr_nxt = w_dec_addr;
            w_tgt_din_nxt  = i_req_din;
            w_busy_nxt     = 1'b1;
            if (w_dec_slow) begin
              w_state_nxt = S_SYNC;
            end else begin
              w_tgt_strobe_nxt = w_dec_sel;
              w_state_nxt      = S_STROBE;
            end
          end else begin
            w_done_nxt    = 1'b1;
            w_err_nxt     = 1'b1;
            w_rd_data_nxt = UNMAPPED_VAL;
          end
        end
      end

      S_SYNC: begin
        if (r_slow_flag) begin
          w_flag_clr       = 1'b1;
          w_tgt_strobe_nxt = r_tgt_sel;
          w_state_nxt      = S_STROBE;
        end
      end

      S_STROBE: begin
        w_tgt_strobe_nxt = 3'b000;
        w_state_nxt      = S_WAIT;
`ifdef IOSEQ_TIMEOUT_EN
        w_to_cnt_nxt     = 16'd0;
`endif
      end

      S_WAIT: begin
        if (w_sel_ack) begin
          if (r_tgt_rw) begin
            w_rd_data_nxt = w_sel_dout;
          end
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
`ifdef IOSEQ_TIMEOUT_EN
        // Ack on the terminal tick takes priority over the timeout.
        else if (r_to_cnt == TIMEOUT_CYCLES - 16'd1) begin
          w_rd_data_nxt = 8'hFF;
          w_done_nxt    = 1'b1;
          w_err_nxt     = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 16'd1;
        end
`endif
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else if (i_cen) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rd_data    <= 8'h00;
      r_tgt_strobe <= 3'b000;
      r_tgt_sel    <= 3'b000;
      r_tgt_rw     <= 1'b1;
      r_tgt_addr   <= 8'h00;
      r_tgt_din    <= 8'h00;
    end else if (i_cen) begin
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_tgt_strobe <= w_tgt_strobe_nxt;
      r_tgt_sel    <= w_tgt_sel_nxt;
      r_tgt_rw     <= w_tgt_rw_nxt;
      r_tgt_addr   <= w_tgt_addr_nxt;
      r_tgt_din    <= w_tgt_din_nxt;
    end
  end

`ifdef IOSEQ_TIMEOUT_EN
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_to_cnt <= 16'd0;
    end else if (i_cen) begin
      r_to_cnt <= w_to_cnt_nxt;
    end
  end
`endif

  // slow_en pulses are only one clk_sys wide and may fall between cen ticks, so
  // they are remembered on every clock. Capture is limited to SYNC so that a
  // pulse seen before the access was accepted cannot release the strobe early.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_slow_flag <= 1'b0;
    end else if (r_state != S_SYNC) begin
      r_slow_flag <= 1'b0;
    end else if (i_cen && w_flag_clr) begin
      r_slow_flag <= 1'b0;
    end else if (i_slow_en) begin
      r_slow_flag <= 1'b1;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_rd_data    = r_rd_data;
  assign o_tgt_strobe = r_tgt_strobe;
  assign o_tgt_rw     = r_tgt_rw;
  assign o_tgt_addr   = r_tgt_addr;
  assign o_tgt_din    = r_tgt_din;

endmodule

// File: tb/tb_iigs_io_sequencer.sv
// tb/tb_iigs_io_sequencer.sv - self-checking bench for iigs_io_sequencer
module tb_iigs_io_sequencer;

  localparam logic [7:0] UNM = 8'h00;
`ifdef IOSEQ_TIMEOUT_EN
  localparam int MAX_DLY = 3;
`else
  localparam int MAX_DLY = 1000;
`endif

  typedef struct {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] din;
    int         ack_dly;
    int         slow_wait;
    bit         noise;
    bit         pre_slow;
    int         exp_tgt;
    logic [7:0] exp_taddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cen = 1'b0;
  logic        slow_en = 1'b0;
  logic        req = 1'b0;
  logic        req_wr = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [7:0]  req_din = 8'h00;
  logic        busy, done, err, tgt_rw;
  logic [7:0]  rd_data, tgt_addr, tgt_din;
  logic [2:0]  tgt_strobe;
  logic [23:0] tgt_dout = 24'h0;
  logic [2:0]  tgt_ack = 3'b000;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  m_rd = 8'h00;
  logic [2:0]  smask = 3'b100;
  logic [7:0]  pool [0:9] = '{8'h00, 8'h10, 8'h26, 8'h44, 8'h63, 8'h70, 8'h33, 8'h34, 8'hE5, 8'hEF};
  vec_t        tbl [0:17];

  always #5 clk = ~clk;

  iigs_io_sequencer #(
    .SLOW_MASK     (3'b100),
    .UNMAPPED_VAL  (UNM),
    .TIMEOUT_CYCLES(16'd4)
  ) dut (
    .i_clk_sys   (clk),
    .i_reset_n   (reset_n),
    .i_cen       (cen),
    .i_slow_en   (slow_en),
    .i_req       (req),
    .i_req_wr    (req_wr),
    .i_req_addr  (req_addr),
    .i_req_din   (req_din),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_rd_data   (rd_data),
    .o_tgt_strobe(tgt_strobe),
    .o_tgt_rw    (tgt_rw),
    .o_tgt_addr  (tgt_addr),
    .o_tgt_din   (tgt_din),
    .i_tgt_dout  (tgt_dout),
    .i_tgt_ack   (tgt_ack)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Target from the documented address map: -1 unmapped, 0 adb, 1 prtc, 2 iwm.
  function automatic int ref_target(input logic [7:0] a);
    if (a inside {8'h00, 8'h10, [8'h24:8'h27], 8'h44, 8'h45, [8'h61:8'h67], 8'h70}) return 0;
    if (a inside {8'h33, 8'h34}) return 1;
    if (a inside {[8'hE0:8'hEF]}) return 2;
    return -1;
  endfunction

  // Advance to just after the next cen tick (sampled at the following negedge),
  // with a random number of non-cen clocks in between; optionally pulse slow_en
  // on one of those in-between clocks.
  task automatic cen_tick(input bit pulse);
    int idle;
    idle = $urandom_range(0, 2);
    if (pulse && idle == 0) idle = 1;
    for (int k = 0; k < idle; k++) begin
      cen = 1'b0;
      slow_en = (pulse && k == idle - 1);
      @(negedge clk);
    end
    slow_en = 1'b0;
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
  endtask

  task automatic run_access(input vec_t v);
    logic [2:0] oh;
    int         dly;
    bit         slow;
    dly = (v.ack_dly > MAX_DLY) ? MAX_DLY : v.ack_dly;
    oh = (v.exp_tgt >= 0) ? 3'(1 << v.exp_tgt) : 3'b000;
    slow = (v.exp_tgt >= 0) && smask[v.exp_tgt];
    if (v.pre_slow) cen_tick(1'b1);
    tgt_dout = 24'($urandom);
    tgt_ack  = 3'b000;
    req_wr   = v.wr;
    req_addr = v.addr;
    req_din  = v.din;
    req      = 1'b1;
    cen_tick(1'b0);
    req = v.noise;
    if (v.exp_tgt < 0) begin
      m_rd = UNM;
      chk("unm_done", done, 1);
      chk("unm_err", err, 1);
      chk("unm_rd", rd_data, m_rd);
      chk("unm_busy", busy, 0);
      chk("unm_strobe", tgt_strobe, 0);
      req = 1'b0;
      cen_tick(1'b0);
      chk("unm_done_clr", done, 0);
      chk("unm_err_clr", err, 0);
      return;
    end
    chk("acc_busy", busy, 1);
    chk("acc_rw", tgt_rw, !v.wr);
    chk("acc_addr", tgt_addr, v.exp_taddr);
    chk("acc_din", tgt_din, v.din);
    if (slow) begin
      chk("sync_nostb", tgt_strobe, 0);
      for (int k = 0; k < v.slow_wait; k++) begin
        cen_tick(1'b0);
        chk("sync_hold_stb", tgt_strobe, 0);
        chk("sync_hold_busy", busy, 1);
      end
      cen_tick(1'b1);
    end
    chk("strobe_on", tgt_strobe, oh);
    chk("strobe_nodone", done, 0);
    cen_tick(1'b0);
    chk("strobe_off", tgt_strobe, 0);
    chk("wait_nodone", done, 0);
    for (int k = 0; k < dly; k++) begin
      tgt_ack = 3'($urandom) & ~oh;
      cen_tick(1'b0);
      chk("ackwait_done", done, 0);
      chk("ackwait_busy", busy, 1);
      chk("ackwait_stb", tgt_strobe, 0);
    end
    tgt_ack = oh | (3'($urandom) & ~oh);
    cen_tick(1'b0);
    if (!v.wr) m_rd = 8'(tgt_dout >> (8 * v.exp_tgt));
    chk("cmp_done", done, 1);
    chk("cmp_err", err, 0);
    chk("cmp_busy", busy, 0);
    chk("cmp_rd", rd_data, m_rd);
    req = 1'b0;
    tgt_ack = 3'b000;
    cen_tick(1'b0);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_stb", tgt_strobe, 0);
    chk("post_rd_hold", rd_data, m_rd);
    chk("post_rw_hold", tgt_rw, !v.wr);
    chk("post_addr_hold", tgt_addr, v.exp_taddr);
    chk("post_din_hold", tgt_din, v.din);
  endtask

  initial begin
    vec_t v;
    // addr, wr, din, ack_dly, slow_wait, noise, pre_slow, exp_tgt, exp_taddr
    tbl[0]  = '{8'h34, 1'b0, 8'h11, 0, 0, 1'b0, 1'b0,  1, 8'h01};
    tbl[1]  = '{8'hE8, 1'b1, 8'h3C, 0, 4, 1'b0, 1'b0,  2, 8'hE8};
    tbl[2]  = '{8'h99, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, -1, 8'h00};
    tbl[3]  = '{8'h10, 1'b0, 8'h22, 7, 0, 1'b1, 1'b0,  0, 8'h10};
    tbl[4]  = '{8'h33, 1'b0, 8'h00, 1, 0, 1'b0, 1'b0,  1, 8'h00};
    tbl[5]  = '{8'h27, 1'b1, 8'hA5, 2, 0, 1'b0, 1'b0,  0, 8'h27};
    tbl[6]  = '{8'h23, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, -1, 8'h00};
    tbl[7]  = '{8'h28, 1'b0, 8'h00, 0, 0, 1'b1, 1'b0, -1, 8'h00};
    tbl[8]  = '{8'h61, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0,  0, 8'h61};
    tbl[9]  = '{8'h67, 1'b1, 8'h7E, 3, 0, 1'b0, 1'b0,  0, 8'h67};
    tbl[10] = '{8'h68, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, -1, 8'h00};
    tbl[11] = '{8'h70, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0,  0, 8'h70};
    tbl[12] = '{8'hDF, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, -1, 8'h00};
    tbl[13] = '{8'hE0, 1'b0, 8'h00, 1, 2, 1'b0, 1'b1,  2, 8'hE0};
    tbl[14] = '{8'hEF, 1'b0, 8'h00, 0, 0, 1'b1, 1'b0,  2, 8'hEF};
    tbl[15] = '{8'hF0, 1'b1, 8'h55, 0, 0, 1'b0, 1'b0, -1, 8'h00};
    tbl[16] = '{8'h45, 1'b1, 8'h5A, 0, 0, 1'b0, 1'b0,  0, 8'h45};
    tbl[17] = '{8'h60, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, -1, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_strobe", tgt_strobe, 0);
    chk("rst_rw", tgt_rw, 1);
    chk("rst_addr", tgt_addr, 0);
    chk("rst_din", tgt_din, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) run_access(tbl[i]);

    // Reset while waiting for an ack aborts the access with no completion.
    req_addr = 8'h44; req_wr = 1'b0; req = 1'b1;
    cen_tick(1'b0);
    req = 1'b0;
    cen_tick(1'b0);
    cen_tick(1'b0);
    chk("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_strobe", tgt_strobe, 0);
    chk("midrst_rw", tgt_rw, 1);
    chk("midrst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_rd = 8'h00;
    tgt_ack = 3'b001;
    cen_tick(1'b0);
    chk("aftrst_nodone", done, 0);
    cen_tick(1'b0);
    chk("aftrst_nodone2", done, 0);
    chk("aftrst_idle", busy, 0);
    tgt_ack = 3'b000;
    run_access(tbl[11]);

`ifdef IOSEQ_TIMEOUT_EN
    // No ack: forced completion on the 4th tick in WAIT.
    tgt_dout = 24'h00A700; tgt_ack = 3'b000;
    req_addr = 8'h33; req_wr = 1'b0; req = 1'b1;
    cen_tick(1'b0);
    req = 1'b0;
    cen_tick(1'b0);
    for (int k = 0; k < 3; k++) begin
      cen_tick(1'b0);
      chk("to_pending", done, 0);
    end
    cen_tick(1'b0);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_rd", rd_data, 8'hFF);
    chk("to_busy", busy, 0);
    cen_tick(1'b0);
    // Ack on the terminal tick wins.
    req = 1'b1;
    cen_tick(1'b0);
    req = 1'b0;
    cen_tick(1'b0);
    for (int k = 0; k < 3; k++) cen_tick(1'b0);
    tgt_ack = 3'b010;
    cen_tick(1'b0);
    chk("toack_done", done, 1);
    chk("toack_err", err, 0);
    chk("toack_rd", rd_data, 8'hA7);
    tgt_ack = 3'b000;
    m_rd = 8'hA7;
    cen_tick(1'b0);
`else
    // Without the timeout option WAIT holds well past any counter limit.
    v = '{8'h45, 1'b0, 8'h00, 70, 0, 1'b0, 1'b0, 0, 8'h45};
    run_access(v);
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) v.addr = 8'($urandom);
      else v.addr = pool[$urandom_range(0, 9)];
      v.wr        = 1'($urandom_range(0, 1));
      v.din       = 8'($urandom);
      v.ack_dly   = $urandom_range(0, 5);
      v.slow_wait = $urandom_range(0, 3);
      v.noise     = 1'($urandom_range(0, 1));
      v.pre_slow  = 1'($urandom_range(0, 1));
      v.exp_tgt   = ref_target(v.addr);
      v.exp_taddr = (v.exp_tgt == 1) ? {7'b0, ~v.addr[0]} : v.addr;
      run_access(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
